// File: rtl/aq_djpeg_coef_buffer.sv
// Dequantise + de-zigzag coefficient buffer: Huffman decoder writes (zigzag index, coef) pairs,
// the iDCT reads completed raster-order blocks two coefficients per address from a bank ring.
module aq_djpeg_coef_buffer #(
    parameter int COEF_W    = 16,
    parameter int QT_W      = 8,
    parameter int NUM_QT    = 2,
    parameter int NUM_BANKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ProcessInit,
    input  logic              QtInEnable,
    input  logic [1:0]        QtInSel,
    input  logic [5:0]        QtInCount,
    input  logic [QT_W-1:0]   QtInData,
    input  logic              DataInEnable,
    input  logic [5:0]        DataInAddress,
    input  logic [COEF_W-1:0] DataInData,
    input  logic [2:0]        DataInColor,
    input  logic [1:0]        DataInQtSel,
    input  logic              DataInEnd,
    output logic              DataInIdle,
    output logic              Overflow,
    output logic              DataOutEnable,
    output logic [2:0]        DataOutColor,
    input  logic              DataOutRead,
    input  logic [4:0]        DataOutAddress,
    output logic [COEF_W-1:0] DataOutA,
    output logic [COEF_W-1:0] DataOutB
);
    localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam int QS_W  = (NUM_QT > 1) ? $clog2(NUM_QT) : 1;
    localparam int NQ    = 1 << QS_W;
    localparam int PW    = COEF_W + QT_W + 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BANKS);
    localparam logic signed [PW-1:0] PMAX = {{(QT_W + 2){1'b0}}, {(COEF_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN = {{(QT_W + 2){1'b1}}, {(COEF_W - 1){1'b0}}};

    localparam int ZZ_ROM [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [QT_W-1:0]   qt_ram [NQ][64];
    logic [COEF_W-1:0] mem    [NUM_BANKS][64];
    logic [63:0]       vmap   [NUM_BANKS];
    logic [2:0]        color_mem [NUM_BANKS];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic              s1_we, s1_end;
    logic [5:0]        s1_zz;
    logic [COEF_W-1:0] s1_coef;
    logic [2:0]        s1_color;
    logic [QS_W-1:0]   s1_qsel;

    logic              s2_we, s2_end;
    logic [5:0]        s2_raster;
    logic [COEF_W-1:0] s2_coef;
    logic [QT_W-1:0]   s2_qt;
    logic [2:0]        s2_color;

    logic [QS_W-1:0]   qt_wsel, in_qsel;
    logic signed [PW-1:0] prod;
    logic [COEF_W-1:0] sat_val;
    logic release_bank, room, commit;
    logic unused_bits;

    assign qt_wsel = (NUM_QT > 1) ? QtInSel[QS_W-1:0] : '0;
    assign in_qsel = (NUM_QT > 1) ? DataInQtSel[QS_W-1:0] : '0;
    assign unused_bits = ^{QtInSel, DataInQtSel};

    assign DataInIdle    = (count != FULL);
    assign DataOutEnable = (count != '0);
    assign DataOutColor  = color_mem[rd_ptr];

    // A full ring only accepts a pipeline write if the oldest bank is released in the same cycle.
    assign release_bank = DataOutRead & DataOutEnable;
    assign room         = (count != FULL) | release_bank;
    assign commit       = s2_end & room;

    assign prod = $signed({{(QT_W + 1){s2_coef[COEF_W-1]}}, s2_coef} * {{COEF_W{1'b0}}, 1'b0, s2_qt});

    always_comb begin
        sat_val = prod[COEF_W-1:0];
        if (prod > PMAX)
            sat_val = {1'b0, {(COEF_W - 1){1'b1}}};
        else if (prod < PMIN)
            sat_val = {1'b1, {(COEF_W - 1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (QtInEnable)
            qt_ram[qt_wsel][QtInCount] <= QtInData;
    end

    always_ff @(posedge clk) begin
        if (s2_we && room)
            mem[wr_ptr][s2_raster] <= sat_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            Overflow  <= 1'b0;
            DataOutA  <= '0;
            DataOutB  <= '0;
            s1_we     <= 1'b0;
            s1_end    <= 1'b0;
            s1_zz     <= '0;
            s1_coef   <= '0;
            s1_color  <= '0;
            s1_qsel   <= '0;
            s2_we     <= 1'b0;
            s2_end    <= 1'b0;
            s2_raster <= '0;
            s2_coef   <= '0;
            s2_qt     <= '0;
            s2_color  <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                vmap[i]      <= '0;
                color_mem[i] <= '0;
            end
        end else begin
            s1_we    <= DataInEnable & DataInIdle;
            s1_end   <= DataInEnd & DataInIdle;
            s1_zz    <= DataInAddress;
            s1_coef  <= DataInData;
            s1_color <= DataInColor;
            s1_qsel  <= in_qsel;

            s2_we     <= s1_we;
            s2_end    <= s1_end;
            s2_raster <= 6'(ZZ_ROM[s1_zz]);
            s2_coef   <= s1_coef;
            s2_qt     <= qt_ram[s1_qsel][s1_zz];
            s2_color  <= s1_color;

            if ((DataInEnable || DataInEnd) && !DataInIdle)
                Overflow <= 1'b1;

            // Banks are cleared as they are freed, so the write bank always starts empty.
            if (release_bank) begin
                vmap[rd_ptr] <= '0;
                rd_ptr       <= ptr_inc(rd_ptr);
            end
            if (s2_we && room)
                vmap[wr_ptr][s2_raster] <= 1'b1;
            if (commit) begin
                color_mem[wr_ptr] <= s2_color;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (commit && !release_bank)
                count <= count + 1'b1;
            else if (!commit && release_bank)
                count <= count - 1'b1;

            DataOutA <= vmap[rd_ptr][{1'b0, DataOutAddress}] ? mem[rd_ptr][{1'b0, DataOutAddress}] : '0;
            DataOutB <= vmap[rd_ptr][{1'b1, DataOutAddress}] ? mem[rd_ptr][{1'b1, DataOutAddress}] : '0;

            if (ProcessInit) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                Overflow <= 1'b0;
                DataOutA <= '0;
                DataOutB <= '0;
                s1_we    <= 1'b0;
                s1_end   <= 1'b0;
                s2_we    <= 1'b0;
                s2_end   <= 1'b0;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    vmap[i]      <= '0;
                    color_mem[i] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_aq_djpeg_coef_buffer.sv
// Directed bench for the coefficient buffer: a 2-bank/2-table instance and a 4-bank/4-table
// instance share all inputs; each is checked against hand-computed raster values.
module tb_aq_djpeg_coef_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ProcessInit = 1'b0;
    logic        QtInEnable = 1'b0;
    logic [1:0]  QtInSel = '0;
    logic [5:0]  QtInCount = '0;
    logic [7:0]  QtInData = '0;
    logic        DataInEnable = 1'b0;
    logic [5:0]  DataInAddress = '0;
    logic [15:0] DataInData = '0;
    logic [2:0]  DataInColor = '0;
    logic [1:0]  DataInQtSel = '0;
    logic        DataInEnd = 1'b0;
    logic        DataOutRead = 1'b0;
    logic [4:0]  DataOutAddress = '0;

    logic        idle2, ovf2, en2;
    logic [2:0]  col2;
    logic [15:0] a2, b2;
    logic        idle4, ovf4, en4;
    logic [2:0]  col4;
    logic [15:0] a4, b4;

    int n_checks = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic [2:0]  col_q[$];

    typedef struct {
        int q;
        int zz;
        int coef;
        int raster;
        int expv;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    aq_djpeg_coef_buffer #(.COEF_W(16), .QT_W(8), .NUM_QT(2), .NUM_BANKS(2)) u_dut2 (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
        .QtInEnable(QtInEnable), .QtInSel(QtInSel), .QtInCount(QtInCount), .QtInData(QtInData),
        .DataInEnable(DataInEnable), .DataInAddress(DataInAddress), .DataInData(DataInData),
        .DataInColor(DataInColor), .DataInQtSel(DataInQtSel), .DataInEnd(DataInEnd),
        .DataInIdle(idle2), .Overflow(ovf2), .DataOutEnable(en2), .DataOutColor(col2),
        .DataOutRead(DataOutRead), .DataOutAddress(DataOutAddress), .DataOutA(a2), .DataOutB(b2)
    );

    aq_djpeg_coef_buffer #(.COEF_W(16), .QT_W(8), .NUM_QT(4), .NUM_BANKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
        .QtInEnable(QtInEnable), .QtInSel(QtInSel), .QtInCount(QtInCount), .QtInData(QtInData),
        .DataInEnable(DataInEnable), .DataInAddress(DataInAddress), .DataInData(DataInData),
        .DataInColor(DataInColor), .DataInQtSel(DataInQtSel), .DataInEnd(DataInEnd),
        .DataInIdle(idle4), .Overflow(ovf4), .DataOutEnable(en4), .DataOutColor(col4),
        .DataOutRead(DataOutRead), .DataOutAddress(DataOutAddress), .DataOutA(a4), .DataOutB(b4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_qt(input int sel, input int idx, input int val);
        QtInEnable = 1'b1;
        QtInSel    = 2'(sel);
        QtInCount  = 6'(idx);
        QtInData   = 8'(val);
        tick();
        QtInEnable = 1'b0;
    endtask

    task automatic send(input int zz, input int coef, input bit en, input bit fin,
                        input int color, input int qsel);
        DataInEnable  = en;
        DataInEnd     = fin;
        DataInAddress = 6'(zz);
        DataInData    = 16'(coef);
        DataInColor   = 3'(color);
        DataInQtSel   = 2'(qsel);
        tick();
        DataInEnable  = 1'b0;
        DataInEnd     = 1'b0;
    endtask

    task automatic read2(input int r, output logic signed [31:0] v);
        logic [5:0] ra;
        ra = 6'(r);
        DataOutAddress = ra[4:0];
        tick();
        v = ra[5] ? 32'($signed(b2)) : 32'($signed(a2));
    endtask

    task automatic release_bank();
        DataOutRead = 1'b1;
        tick();
        DataOutRead = 1'b0;
    endtask

    logic signed [31:0] v;

    initial begin
        vecs[0] = '{255, 1, 200, 1, 32767};
        vecs[1] = '{255, 1, -200, 1, -32768};
        vecs[2] = '{3, 2, -5, 8, -15};
        vecs[3] = '{1, 63, -1, 63, -1};
        vecs[4] = '{2, 10, 1000, 32, 2000};
        vecs[5] = '{7, 35, -13, 56, -91};
        vecs[6] = '{128, 20, 256, 40, 32767};
        vecs[7] = '{128, 20, -256, 40, -32768};
        vecs[8] = '{255, 27, 128, 6, 32640};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_idle", 32'(idle2), 1);
        chk("rst_ovf", 32'(ovf2), 0);
        chk("rst_en", 32'(en2), 0);
        chk("rst_color", 32'(col2), 0);
        chk("rst_a", 32'(a2), 0);
        chk("rst_b", 32'(b2), 0);

        // Four blocks through four tables on the 4-bank instance
        for (int k = 0; k < 4; k++) load_qt(k, 0, k + 1);
        for (int k = 0; k < 4; k++) begin
            send(0, 10, 1, 1, k, k);
            exp_q.push_back(16'(10 * (k + 1)));
        end
        tick();
        tick();
        chk("b4_full_idle", 32'(idle4), 0);
        chk("b4_en", 32'(en4), 1);
        for (int k = 0; k < 4; k++) begin
            DataOutAddress = '0;
            tick();
            chk("b4_dc", 32'($signed(a4)), 32'($signed(exp_q.pop_front())));
            chk("b4_color", 32'(col4), k);
            release_bank();
        end
        chk("b4_empty", 32'(en4), 0);
        ProcessInit = 1'b1;
        tick();
        ProcessInit = 1'b0;
        chk("pinit_ovf", 32'(ovf2), 0);
        chk("pinit_idle", 32'(idle2), 1);

        // Basic block with latency check
        for (int i = 0; i < 64; i++) load_qt(0, i, 1);
        send(0, 100, 1, 0, 0, 0);
        send(2, -5, 1, 1, 0, 0);
        tick();
        chk("lat_t2", 32'(en2), 0);
        tick();
        chk("lat_t3", 32'(en2), 1);
        read2(0, v);  chk("t1_r0", v, 100);
        read2(32, v); chk("t1_r32", v, 0);
        read2(8, v);  chk("t1_r8", v, -5);
        read2(1, v);  chk("t1_r1", v, 0);
        read2(63, v); chk("t1_r63", v, 0);
        release_bank();
        chk("t1_released", 32'(en2), 0);

        // Single-coefficient blocks: mapping, scaling, saturation
        for (int i = 0; i < 9; i++) begin
            load_qt(0, vecs[i].zz, vecs[i].q);
            send(vecs[i].zz, vecs[i].coef, 1, 1, 0, 0);
            tick();
            tick();
            chk("vec_en", 32'(en2), 1);
            read2(vecs[i].raster, v);
            chk("vec_val", v, vecs[i].expv);
            read2(vecs[i].raster ^ 1, v);
            chk("vec_zero", v, 0);
            release_bank();
        end
        for (int i = 0; i < 64; i++) load_qt(0, i, 1);

        // Full ring, dropped input and sticky overflow
        send(0, 1, 1, 1, 0, 0);
        send(0, 2, 1, 1, 0, 0);
        tick();
        tick();
        chk("full_idle", 32'(idle2), 0);
        chk("full_ovf0", 32'(ovf2), 0);
        send(0, 9, 1, 1, 0, 0);
        chk("drop_ovf", 32'(ovf2), 1);
        repeat (3) tick();
        chk("drop_still_full", 32'(idle2), 0);
        read2(0, v); chk("full_dc0", v, 1);
        release_bank();
        chk("rel_idle", 32'(idle2), 1);
        read2(0, v); chk("full_dc1", v, 2);
        release_bank();
        chk("full_empty", 32'(en2), 0);
        chk("ovf_sticky", 32'(ovf2), 1);

        // Commit coinciding with release keeps the count; colors stay in order
        col_q.push_back(3'd0);
        col_q.push_back(3'd1);
        col_q.push_back(3'd2);
        send(0, 10, 1, 1, 0, 0);
        tick();
        tick();
        chk("c0_color", 32'(col2), 32'(col_q.pop_front()));
        send(0, 11, 1, 1, 1, 0);
        tick();
        DataOutRead = 1'b1;
        tick();
        DataOutRead = 1'b0;
        chk("co_en", 32'(en2), 1);
        chk("co_idle", 32'(idle2), 1);
        chk("c1_color", 32'(col2), 32'(col_q.pop_front()));
        send(0, 12, 1, 1, 2, 0);
        tick();
        tick();
        chk("co_full", 32'(idle2), 0);
        read2(0, v); chk("c1_dc", v, 11);
        release_bank();
        chk("c2_color", 32'(col2), 32'(col_q.pop_front()));
        read2(0, v); chk("c2_dc", v, 12);
        release_bank();

        // ProcessInit mid-block, with one entry still in flight
        send(5, 7, 1, 0, 0, 0);
        ProcessInit = 1'b1;
        tick();
        ProcessInit = 1'b0;
        chk("pi_en", 32'(en2), 0);
        chk("pi_ovf", 32'(ovf2), 0);
        send(5, 7, 1, 0, 0, 0);
        ProcessInit = 1'b1;
        tick();
        ProcessInit = 1'b0;
        repeat (3) tick();
        chk("pi_en_later", 32'(en2), 0);
        send(0, 3, 1, 1, 0, 0);
        tick();
        tick();
        chk("pi_next_en", 32'(en2), 1);
        read2(0, v); chk("pi_r0", v, 3);
        read2(2, v); chk("pi_r2", v, 0);
        read2(5, v); chk("pi_r5", v, 0);

        // Asynchronous reset between clock edges
        read2(0, v); chk("ar_pre", v, 3);
        #2 rst = 1'b1;
        #1;
        chk("ar_en", 32'(en2), 0);
        chk("ar_idle", 32'(idle2), 1);
        chk("ar_a", 32'(a2), 0);
        tick();
        rst = 1'b0;
        tick();
        read2(0, v); chk("ar_after", v, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
